// File: rtl/arf_ctrl_seq.sv
// Command sequencer for the 8-bit address register file: drives ARF selects and memory strobes.
// Optional stack depth guard enabled with `define ARF_STACK_GUARD_EN.
module arf_ctrl_seq #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] STACK_TOP   = 8'hFF,
    parameter int unsigned      STACK_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] arf_i,
    output logic [1:0]       arf_fun_sel,
    output logic [3:0]       arf_rsel,
    output logic [1:0]       arf_out_a_sel,
    output logic [1:0]       arf_out_b_sel,
    output logic             mem_rd,
    output logic             mem_wr
);

    localparam logic [1:0] OpFetch = 2'b00;
    localparam logic [1:0] OpJump  = 2'b01;
    localparam logic [1:0] OpPush  = 2'b10;
    localparam logic [1:0] OpPop   = 2'b11;

    localparam logic [1:0] FunClr = 2'b00;
    localparam logic [1:0] FunLd  = 2'b01;
    localparam logic [1:0] FunDec = 2'b10;
    localparam logic [1:0] FunInc = 2'b11;

    localparam logic [1:0] SelAr = 2'b00;
    localparam logic [1:0] SelSp = 2'b01;
    localparam logic [1:0] SelPc = 2'b11;

    typedef enum logic [3:0] {
        StInitClr,
        StInitSp,
        StIdle,
        StFAddr,
        StFInc,
        StJLoad,
        StPuAddr,
        StPuDec,
        StPoInc,
        StPoAddr,
        StGErr
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] target_q;
    logic             accept;
    logic             stack_full;
    logic             stack_empty;

    if (STACK_DEPTH == 0) begin : g_bad_depth
        $error("arf_ctrl_seq: STACK_DEPTH must be nonzero");
    end

    assign accept = cmd_valid && (state_q == StIdle);

`ifdef ARF_STACK_GUARD_EN
    localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);

    logic [DepthW-1:0] depth_q;

    assign stack_full  = (depth_q == DepthW'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else if (state_q == StPuDec) begin
            depth_q <= depth_q + DepthW'(1);
        end else if (state_q == StPoInc) begin
            depth_q <= depth_q - DepthW'(1);
        end
    end
`else
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StInitClr;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                target_q <= cmd_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInitClr: state_d = StInitSp;
            StInitSp:  state_d = StIdle;
            StIdle: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OpFetch: state_d = StFAddr;
                        OpJump:  state_d = StJLoad;
                        OpPush:  state_d = stack_full  ? StGErr : StPuAddr;
                        OpPop:   state_d = stack_empty ? StGErr : StPoInc;
                        default: state_d = StIdle;
                    endcase
                end
            end
            StFAddr:  state_d = StFInc;
            StPuAddr: state_d = StPuDec;
            StPoInc:  state_d = StPoAddr;
            StFInc, StJLoad, StPuDec, StPoAddr, StGErr: state_d = StIdle;
            default:  state_d = StInitClr;
        endcase
    end

    // Moore decode: outputs depend only on state_q and target_q.
    always_comb begin
        cmd_ready     = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        arf_i         = '0;
        arf_fun_sel   = FunClr;
        arf_rsel      = 4'b0000;
        arf_out_a_sel = SelPc;
        arf_out_b_sel = SelAr;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        case (state_q)
            StInitClr: begin
                arf_rsel    = 4'b1111;
                arf_fun_sel = FunClr;
            end
            StInitSp: begin
                arf_i       = STACK_TOP;
                arf_fun_sel = FunLd;
                arf_rsel    = 4'b0010;
            end
            StIdle: cmd_ready = 1'b1;
            StFAddr: begin
                arf_out_b_sel = SelPc;
                mem_rd        = 1'b1;
            end
            StFInc: begin
                arf_fun_sel = FunInc;
                arf_rsel    = 4'b1000;
                done        = 1'b1;
            end
            StJLoad: begin
                arf_i       = target_q;
                arf_fun_sel = FunLd;
                arf_rsel    = 4'b1000;
                done        = 1'b1;
            end
            StPuAddr: begin
                arf_out_b_sel = SelSp;
                mem_wr        = 1'b1;
            end
            StPuDec: begin
                arf_fun_sel = FunDec;
                arf_rsel    = 4'b0010;
                done        = 1'b1;
            end
            StPoInc: begin
                arf_fun_sel = FunInc;
                arf_rsel    = 4'b0010;
            end
            StPoAddr: begin
                arf_out_b_sel = SelSp;
                mem_rd        = 1'b1;
                done          = 1'b1;
            end
            StGErr: begin
                done = 1'b1;
`ifdef ARF_STACK_GUARD_EN
                err  = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arf_ctrl_seq.sv
// Directed, table-driven bench for arf_ctrl_seq; guard checks build when ARF_STACK_GUARD_EN is set.
module tb_arf_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       done;
    logic       err;
    logic [7:0] arf_i;
    logic [1:0] arf_fun_sel;
    logic [3:0] arf_rsel;
    logic [1:0] arf_out_a_sel;
    logic [1:0] arf_out_b_sel;
    logic       mem_rd;
    logic       mem_wr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arf_ctrl_seq dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .done         (done),
        .err          (err),
        .arf_i        (arf_i),
        .arf_fun_sel  (arf_fun_sel),
        .arf_rsel     (arf_rsel),
        .arf_out_a_sel(arf_out_a_sel),
        .arf_out_b_sel(arf_out_b_sel),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr)
    );

    typedef struct packed {
        logic       ready;
        logic       done;
        logic       err;
        logic [7:0] ai;
        logic [1:0] fs;
        logic [3:0] rs;
        logic [1:0] as;
        logic [1:0] bs;
        logic       rd;
        logic       wr;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic       valid;
        logic [1:0] op;
        logic [7:0] data;
        outs_t      exp;
    } vec_t;

    outs_t got;
    assign got = '{cmd_ready, done, err, arf_i, arf_fun_sel, arf_rsel,
                   arf_out_a_sel, arf_out_b_sel, mem_rd, mem_wr};

    function automatic outs_t mk(logic r, logic d, logic e, logic [7:0] ai, logic [1:0] fs,
                                 logic [3:0] rs, logic [1:0] bs, logic rd, logic wr);
        return '{r, d, e, ai, fs, rs, 2'b11, bs, rd, wr};
    endfunction

    // Expected output patterns, one per sequencer step.
    outs_t o_clr, o_sp, o_idle, o_faddr, o_finc, o_puaddr, o_pudec, o_poinc, o_poaddr, o_gerr;

    task automatic check(input string name, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] op, input logic [7:0] d);
        rst       = r;
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
    endtask

    vec_t vecs[18];

    initial begin
        o_clr    = mk(0, 0, 0, 8'h00, 2'b00, 4'b1111, 2'b00, 0, 0);
        o_sp     = mk(0, 0, 0, 8'hFF, 2'b01, 4'b0010, 2'b00, 0, 0);
        o_idle   = mk(1, 0, 0, 8'h00, 2'b00, 4'b0000, 2'b00, 0, 0);
        o_faddr  = mk(0, 0, 0, 8'h00, 2'b00, 4'b0000, 2'b11, 1, 0);
        o_finc   = mk(0, 1, 0, 8'h00, 2'b11, 4'b1000, 2'b00, 0, 0);
        o_puaddr = mk(0, 0, 0, 8'h00, 2'b00, 4'b0000, 2'b01, 0, 1);
        o_pudec  = mk(0, 1, 0, 8'h00, 2'b10, 4'b0010, 2'b00, 0, 0);
        o_poinc  = mk(0, 0, 0, 8'h00, 2'b11, 4'b0010, 2'b00, 0, 0);
        o_poaddr = mk(0, 1, 0, 8'h00, 2'b00, 4'b0000, 2'b01, 1, 0);
        o_gerr   = mk(0, 1, 1, 8'h00, 2'b00, 4'b0000, 2'b00, 0, 0);

        vecs[0]  = '{"reset_clr",      1, 0, 2'b00, 8'h00, o_clr};
        vecs[1]  = '{"init_sp",        0, 0, 2'b00, 8'h00, o_sp};
        vecs[2]  = '{"init_idle",      0, 0, 2'b00, 8'h00, o_idle};
        vecs[3]  = '{"fetch_addr",     0, 1, 2'b00, 8'h00, o_faddr};
        vecs[4]  = '{"fetch_inc",      0, 0, 2'b00, 8'h00, o_finc};
        vecs[5]  = '{"fetch_ready",    0, 0, 2'b00, 8'h00, o_idle};
        vecs[6]  = '{"jump_load",      0, 1, 2'b01, 8'h5A,
                     mk(0, 1, 0, 8'h5A, 2'b01, 4'b1000, 2'b00, 0, 0)};
        vecs[7]  = '{"jump_ready",     0, 0, 2'b00, 8'h00, o_idle};
        vecs[8]  = '{"push_addr",      0, 1, 2'b10, 8'h00, o_puaddr};
        vecs[9]  = '{"push_dec_held",  0, 1, 2'b11, 8'h00, o_pudec};
        vecs[10] = '{"pop_wait_idle",  0, 1, 2'b11, 8'h00, o_idle};
        vecs[11] = '{"pop_inc",        0, 1, 2'b11, 8'h00, o_poinc};
        vecs[12] = '{"pop_addr",       0, 0, 2'b00, 8'h00, o_poaddr};
        vecs[13] = '{"pop_ready",      0, 0, 2'b00, 8'h00, o_idle};
        vecs[14] = '{"fetch2_addr",    0, 1, 2'b00, 8'h00, o_faddr};
        vecs[15] = '{"rst_in_faddr",   1, 0, 2'b00, 8'h00, o_clr};
        vecs[16] = '{"rst_init_sp",    0, 0, 2'b00, 8'h00, o_sp};
        vecs[17] = '{"rst_idle",       0, 0, 2'b00, 8'h00, o_idle};

        drive(1, 0, 2'b00, 8'h00);
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].data);
            @(negedge clk);
            check(vecs[i].name, vecs[i].exp);
        end

        // Target must come from the latch, not the live cmd_data.
        drive(0, 1, 2'b01, 8'h3C);
        @(posedge clk);
        #1;
        drive(0, 0, 2'b00, 8'hA5);
        @(negedge clk);
        check("jump_latched", mk(0, 1, 0, 8'h3C, 2'b01, 4'b1000, 2'b00, 0, 0));
        @(negedge clk);
        check("jump_idle", o_idle);

        // POP straight after init: stack empty.
        drive(0, 1, 2'b11, 8'h00);
        @(negedge clk);
`ifdef ARF_STACK_GUARD_EN
        check("pop_empty_err", o_gerr);
        drive(0, 0, 2'b00, 8'h00);
        @(negedge clk);
        check("pop_empty_idle", o_idle);

        for (int n = 0; n < 16; n++) begin
            drive(0, 1, 2'b10, 8'h00);
            @(negedge clk);
            check($sformatf("push%0d_addr", n), o_puaddr);
            drive(0, 0, 2'b00, 8'h00);
            @(negedge clk);
            check($sformatf("push%0d_dec", n), o_pudec);
            @(negedge clk);
            check($sformatf("push%0d_idle", n), o_idle);
        end
        drive(0, 1, 2'b10, 8'h00);
        @(negedge clk);
        check("push_full_err", o_gerr);
        drive(0, 0, 2'b00, 8'h00);
        @(negedge clk);
        check("push_full_idle", o_idle);
`else
        check("pop_wrap_inc", o_poinc);
        drive(0, 0, 2'b00, 8'h00);
        @(negedge clk);
        check("pop_wrap_addr", o_poaddr);
        @(negedge clk);
        check("pop_wrap_idle", o_idle);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
